// File: rtl/evict_wb_buffer.sv
// Writeback buffer for modified lines evicted from the cache. It queues dirty
// victims in FIFO order, issues one writeback at a time and answers bus snoops.
module evict_wb_buffer #(
  parameter int TAG_SIZE    = 12,
  parameter int INDEX_SIZE  = 14,
  parameter int OFFSET_SIZE = 6,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ev_valid,
  output logic                     ev_ready,
  input  logic [TAG_SIZE-1:0]      ev_tag,
  input  logic [INDEX_SIZE-1:0]    ev_index,
  input  logic [2:0]               ev_way,
  input  logic [1:0]               ev_mesi,
  output logic                     wb_req,
  output logic [31:0]              wb_addr,
  input  logic                     wb_ack,
  input  logic                     snoop_valid,
  input  logic [31:0]              snoop_addr,
  output logic                     snoop_hit,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  localparam logic [1:0] MESI_M = 2'd3;

  logic [TAG_SIZE-1:0]   tag_mem   [DEPTH];
  logic [INDEX_SIZE-1:0] index_mem [DEPTH];
  logic [2:0]            way_mem   [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [0:0]       state;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] rel;

  // Clean victims need no writeback, so they are always taken and dropped.
  assign full     = (count == CNT_W'(DEPTH));
  assign ev_ready = !full || (ev_mesi != MESI_M);
  assign push     = ev_valid && (ev_mesi == MESI_M) && !full;
  assign pop      = (state == REQ) && wb_ack;

  assign wb_req  = (state == REQ);
  assign wb_addr = wb_req ? {tag_mem[head], index_mem[head], {OFFSET_SIZE{1'b0}}} : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= IDLE;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);

      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);

      case (state)
        IDLE:    if (count != '0) state <= REQ;
        REQ:     if (wb_ack)      state <= IDLE;
        default:                  state <= IDLE;
      endcase
    end
  end

  // Entry storage carries no reset; validity comes purely from head and count.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      tag_mem[tail]   <= ev_tag;
      index_mem[tail] <= ev_index;
      way_mem[tail]   <= ev_way;
    end
  end

  // An entry is live when its distance from head is below count.
  always_comb begin
    snoop_hit = 1'b0;
    rel       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = PTR_W'(i) - head;
      if (snoop_valid && ({1'b0, rel} < count) &&
          (tag_mem[i] == snoop_addr[31 -: TAG_SIZE]) &&
          (index_mem[i] == snoop_addr[OFFSET_SIZE +: INDEX_SIZE]))
        snoop_hit = 1'b1;
    end
  end

  // The victim way is kept for debug visibility only.
  logic unused_bits;
  assign unused_bits = ^{snoop_addr[OFFSET_SIZE-1:0], way_mem[head]};

endmodule
